// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing
// Brief    : VGA raster timing generator. Runs at 4x pixel rate; a 2-bit
//            phase counter divides each pixel slot into four clocks, and the
//            horizontal/vertical counters advance once per slot.
//            Optional macro VGA_SYNC_DELAY_EN delays hsync, vsync and active
//            by one pixel slot (4 clks) to line them up with a registered
//            colour path downstream.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] pixel_state,
  output logic [9:0] pixel_counter,
  output logic [8:0] line_counter,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int C_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int C_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] c_h_last     = 10'(C_H_TOTAL - 1);
  localparam logic [9:0] c_v_last     = 10'(C_V_TOTAL - 1);
  localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
  localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
  localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // r_run is low in reset and for the first clk after release; that first
  // edge only arms the counters, so the frame origin is presented for one
  // full clk before the phase starts advancing.
  logic       r_run;
  logic [1:0] r_ps;
  logic [9:0] r_h;
  logic [9:0] r_v;

  logic w_active;
  logic w_hsync;
  logic w_vsync;

  // Phase, horizontal and vertical counters; a frame-end wrap clears both
  // counters on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_ps  <= 2'd0;
      r_h   <= 10'd0;
      r_v   <= 10'd0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      r_ps <= r_ps + 2'd1;
      if (r_ps == 2'd3) begin
        if (r_h == c_h_last) begin
          r_h <= 10'd0;
          if (r_v == c_v_last) r_v <= 10'd0;
          else                 r_v <= r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  // Zero-latency decodes from registered counter state only.
  always_comb begin
    w_active = r_run && (r_h < c_h_vis) && (r_v < c_v_vis);
    w_hsync  = !((r_h >= c_hs_start) && (r_h < c_hs_end));
    w_vsync  = !((r_v >= c_vs_start) && (r_v < c_vs_end));
  end

  // Undelayed outputs: phase, position, row and frame origin pulse.
  always_comb begin
    pixel_state   = r_ps;
    pixel_counter = r_h;
    line_counter  = (r_v < c_v_vis) ? r_v[8:0] : 9'd0;
    frame_start   = r_run && (r_ps == 2'd0) && (r_h == 10'd0) && (r_v == 10'd0);
  end

`ifdef VGA_SYNC_DELAY_EN
  logic [3:0] r_hs_dly;
  logic [3:0] r_vs_dly;
  logic [3:0] r_act_dly;

  // Four-stage shift registers: one pixel slot of delay on sync and active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_dly  <= 4'hF;
      r_vs_dly  <= 4'hF;
      r_act_dly <= 4'h0;
    end else begin
      r_hs_dly  <= {r_hs_dly[2:0], w_hsync};
      r_vs_dly  <= {r_vs_dly[2:0], w_vsync};
      r_act_dly <= {r_act_dly[2:0], w_active};
    end
  end

  // Delayed sync/active taps.
  always_comb begin
    hsync  = r_hs_dly[3];
    vsync  = r_vs_dly[3];
    active = r_act_dly[3];
  end
`else
  // Direct sync/active decodes.
  always_comb begin
    hsync  = w_hsync;
    vsync  = w_vsync;
    active = w_active;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing
// Brief    : Self-checking bench for vga_timing using reduced raster
//            parameters. Expected outputs come from a reference model indexed
//            by clocks since reset release and are queued at each clk edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

  localparam int HV = 16, HF = 4, HS = 6, HB = 4;
  localparam int VV = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;   // 30
  localparam int VT = VV + VF + VS + VB;   // 15
  localparam int FRAME_CLKS = HT * VT * 4; // 1800

  typedef struct packed {
    logic [1:0] ps;
    logic [9:0] pc;
    logic [8:0] lc;
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [1:0] pixel_state;
  logic [9:0] pixel_counter;
  logic [8:0] line_counter;
  logic       active, hsync, vsync, frame_start;

  int checks   = 0;
  int failures = 0;

  exp_t q[$];
  exp_t e;
  int   m_t = -1;

  vga_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pixel_state  (pixel_state),
    .pixel_counter(pixel_counter),
    .line_counter (line_counter),
    .active       (active),
    .hsync        (hsync),
    .vsync        (vsync),
    .frame_start  (frame_start)
  );

  wire exp_t obs = {pixel_state, pixel_counter, line_counter, active, hsync, vsync, frame_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: t = clocks since the arming edge after reset release.
  function automatic exp_t undelayed(int t);
    exp_t r;
    int slot, h, v;
    if (t < 0) begin
      r = '{ps: 2'd0, pc: 10'd0, lc: 9'd0, act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
      return r;
    end
    slot = t / 4;
    h    = slot % HT;
    v    = (slot / HT) % VT;
    r.ps  = 2'(t % 4);
    r.pc  = 10'(h);
    r.lc  = (v < VV) ? 9'(v) : 9'd0;
    r.act = (h < HV) && (v < VV);
    r.hs  = !((h >= HV + HF) && (h < HV + HF + HS));
    r.vs  = !((v >= VV + VF) && (v < VV + VF + VS));
    r.fs  = (t % FRAME_CLKS) == 0;
    return r;
  endfunction

  function automatic exp_t model(int t);
    exp_t r, d;
    r = undelayed(t);
`ifdef VGA_SYNC_DELAY_EN
    d = undelayed((t < 0) ? -1 : t - 4);
    r.act = d.act;
    r.hs  = d.hs;
    r.vs  = d.vs;
`else
    d = r;
`endif
    return r;
  endfunction

  always @(negedge rst_n) m_t = -1;

  always @(posedge clk) begin
    if (rst_n) m_t = m_t + 1;
    else       m_t = -1;
    q.push_back(model(m_t));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to the next sampling point and pop that edge's expectation.
  task automatic step();
    @(negedge clk);
    if (q.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty at time %0t", $time);
      e = '0;
    end else begin
      e = q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== exp_t'({2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0})) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", obs,
               exp_t'({2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
    end
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (pixel_state !== 2'(i % 4)) begin
        failures++;
        $display("FAIL release_phase[%0d] got=%0d want=%0d", i, pixel_state, i % 4);
      end
      checks++;
      if (frame_start !== (i == 0)) begin
        failures++;
        $display("FAIL release_frame_start[%0d] got=%b want=%b", i, frame_start, (i == 0));
      end
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL release_outputs[%0d] got=%h want=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_line();
    int n, low;
    n = 0;
    do begin step(); n++; end while (!(e.pc == 10'(HV) && e.ps == 2'd0) && n < 4 * HT + 8);
    checks++;
    if (n >= 4 * HT + 8) begin
      failures++;
      $display("FAIL line_wait got=timeout want=pixel_counter %0d", HV);
    end
    checks++;
    if (pixel_counter !== 10'(HV) || obs !== e) begin
      failures++;
      $display("FAIL hblank_entry got=%h want=%h", obs, e);
    end
    low = (hsync === 1'b0) ? 1 : 0;
    for (int i = 1; i < 4 * HT; i++) begin
      step();
      if (hsync === 1'b0) low++;
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL line_outputs pc=%0d got=%h want=%h", e.pc, obs, e);
      end
    end
    checks++;
    if (low != 4 * HS) begin
      failures++;
      $display("FAIL hsync_width got=%0d want=%0d", low, 4 * HS);
    end
  endtask

  task automatic test_frame();
    int n, period, vlow, bad;
    n = 0;
    do begin step(); n++; end while (frame_start !== 1'b1 && n < FRAME_CLKS + 8);
    checks++;
    if (n >= FRAME_CLKS + 8) begin
      failures++;
      $display("FAIL frame_wait got=timeout want=frame_start");
    end
    period = 0; vlow = 0; bad = 0;
    do begin
      step(); period++;
      if (vsync === 1'b0) vlow++;
      if (obs !== e) begin
        bad++;
        if (bad <= 4) $display("FAIL frame_outputs t=%0d got=%h want=%h", m_t, obs, e);
      end
    end while (frame_start !== 1'b1 && period < FRAME_CLKS + 8);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frame_output_errors got=%0d want=0", bad);
    end
    checks++;
    if (period != FRAME_CLKS) begin
      failures++;
      $display("FAIL frame_period got=%0d want=%0d", period, FRAME_CLKS);
    end
    checks++;
    if (vlow != 4 * HT * VS) begin
      failures++;
      $display("FAIL vsync_width got=%0d want=%0d", vlow, 4 * HT * VS);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    n = 0;
    while (!(((m_t / 4) % HT) == HV + HF + 1 && ((m_t / 4 / HT) % VT) == VV + VF &&
             (m_t % 4) == 1) && n < 2 * FRAME_CLKS) begin
      step(); n++;
    end
    checks++;
    if (n >= 2 * FRAME_CLKS) begin
      failures++;
      $display("FAIL mid_reset_wait got=timeout want=sync region");
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== exp_t'({2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0})) begin
      failures++;
      $display("FAIL mid_reset_immediate got=%h want=%h", obs,
               exp_t'({2'd0, 10'd0, 9'd0, 1'b0, 1'b1, 1'b1, 1'b0}));
    end
    q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_reset_hold[%0d] got=%h want=%h", i, obs, e);
      end
    end
    rst_n = 1'b1;
    q.delete();
    step();
    checks++;
    if (frame_start !== 1'b1 || obs !== e) begin
      failures++;
      $display("FAIL mid_reset_restart got=%h want=%h", obs, e);
    end
    step();
    checks++;
    if (frame_start !== 1'b0 || pixel_state !== 2'd1) begin
      failures++;
      $display("FAIL mid_reset_second got=fs%b ps%0d want=fs0 ps1", frame_start, pixel_state);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
